insmemloader: RTL and testbench



---
 rtl/insmemloader.sv | 121 ++++++++++++
 tb/tb_insmemloader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insmemloader.sv
// Byte-stream instruction memory loader: packs three big-endian bytes into one
// instruction and writes consecutive words from address 0 until a halt word.
module insmemloader #(
  parameter int ADDR_W = 12,
  parameter int INS_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        inData,
  input  logic              inValid,
  output logic              inReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [INS_W-1:0]  wrData,
  output logic              cpuHold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wordCount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    B0    = 3'd1,
    B1    = 3'd2,
    B2    = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [INS_W-17:0]   ins_hi;
  logic [7:0]          ins_mid;

  logic byte_taken;
  assign byte_taken = inValid && inReady;

  // Load sequencer; every output is registered alongside the state it decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      ins_hi    <= '0;
      ins_mid   <= 8'd0;
      inReady   <= 1'b0;
      wrEn      <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      cpuHold   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wordCount <= '0;
    end else begin
      wrEn <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= B0;
            addr      <= '0;
            wordCount <= '0;
            cpuHold   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            inReady   <= 1'b1;
          end
        end
        B0: begin
          if (byte_taken) begin
            // Only the low three bits carry instruction bits in the first byte.
            if (inData[7:3] != 5'd0) begin
              state   <= ERR;
              err     <= 1'b1;
              inReady <= 1'b0;
            end else begin
              ins_hi <= inData[2:0];
              state  <= B1;
            end
          end
        end
        B1: begin
          if (byte_taken) begin
            ins_mid <= inData;
            state   <= B2;
          end
        end
        B2: begin
          if (byte_taken) begin
            state     <= WRITE;
            inReady   <= 1'b0;
            wrEn      <= 1'b1;
            wrAddr    <= addr;
            wrData    <= {ins_hi, ins_mid, inData};
            wordCount <= wordCount + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        WRITE: begin
          if (wrData == '0) begin
            state   <= DONE;
            done    <= 1'b1;
            cpuHold <= 1'b0;
          end else if (&addr) begin
            // Memory full without a halt: never wrap onto address 0.
            state <= ERR;
            err   <= 1'b1;
          end else begin
            addr    <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            state   <= B0;
            inReady <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          inReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insmemloader.sv
// Randomized self-checking bench for insmemloader against a byte-stream program model.
module tb_insmemloader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  inData = 8'd0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        wrEn;
  logic [11:0] wrAddr;
  logic [18:0] wrData;
  logic        cpuHold;
  logic        done;
  logic        err;
  logic [12:0] wordCount;

  insmemloader dut (
    .clk(clk), .rst(rst), .start(start), .inData(inData), .inValid(inValid),
    .inReady(inReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .cpuHold(cpuHold), .done(done), .err(err), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc;
  int end_cyc;

  logic [7:0]  bytes_q[$];
  logic [11:0] got_addr[$];
  logic [18:0] got_data[$];
  int          got_cyc[$];
  logic [11:0] exp_addr[$];
  logic [18:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_wc;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe the memory would see.
  always @(negedge clk) begin
    if (wrEn) begin
      got_addr.push_back(wrAddr);
      got_data.push_back(wrData);
      got_cyc.push_back(cyc);
    end
  end

  task automatic clear_got();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
  endtask

  task automatic push_ins(input logic [18:0] v);
    bytes_q.push_back({5'd0, v[18:16]});
    bytes_q.push_back(v[15:8]);
    bytes_q.push_back(v[7:0]);
  endtask

  // Program model: consume the stream three bytes at a time.
  task automatic model();
    logic [18:0] ins;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_wc = 0;
    for (int k = 0; 3 * k + 2 < bytes_q.size(); k++) begin
      if (bytes_q[3*k] > 8'd7) begin
        exp_err = 1'b1;
        break;
      end
      ins = {bytes_q[3*k][2:0], bytes_q[3*k+1], bytes_q[3*k+2]};
      exp_addr.push_back(k[11:0]);
      exp_data.push_back(ins);
      exp_wc = k + 1;
      if (ins == 19'd0) begin
        exp_done = 1'b1;
        break;
      end
      if (k == 4095) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; inValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic feed(input int gap_at, input int gap_len, input bit rnd, input int budget);
    int idx = 0;
    int stall = 0;
    int n = 0;
    while (idx < bytes_q.size() && n < budget && !(done || err)) begin
      if (stall > 0) begin
        inValid = 1'b0;
        stall--;
      end else begin
        inValid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        inData  = bytes_q[idx];
      end
      if (inValid && inReady) begin
        if (idx == gap_at) stall = gap_len;
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    inValid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    checks++;
    if (!(done || err)) begin
      errors++;
      $display("FAIL wait_end: neither done nor err after %0d cycles, required one of them", budget);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    inValid = 1'b1; inData = 8'h5A;
    checks += 8;
    if (inReady !== 1'b0)    begin errors++; $display("FAIL rst_inReady: got %b want 0", inReady); end
    if (wrEn !== 1'b0)       begin errors++; $display("FAIL rst_wrEn: got %b want 0", wrEn); end
    if (wrAddr !== 12'd0)    begin errors++; $display("FAIL rst_wrAddr: got %0h want 0", wrAddr); end
    if (wrData !== 19'd0)    begin errors++; $display("FAIL rst_wrData: got %0h want 0", wrData); end
    if (cpuHold !== 1'b0)    begin errors++; $display("FAIL rst_cpuHold: got %b want 0", cpuHold); end
    if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (err !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    if (wordCount !== 13'd0) begin errors++; $display("FAIL rst_wordCount: got %0d want 0", wordCount); end
    clear_got();
    repeat (3) @(negedge clk);
    checks++;
    if (inReady !== 1'b0 || got_addr.size() != 0) begin
      errors++; $display("FAIL idle_no_start: inReady=%b writes=%0d want 0 and 0", inReady, got_addr.size());
    end
    inValid = 1'b0;
  endtask

  task automatic run_fixed(input int gap_len, input string tag);
    int base;
    bytes_q.delete();
    push_ins(19'h07000); push_ins(19'h5190A); push_ins(19'h00000);
    model();
    clear_got();
    pulse_start();
    checks++;
    if (inReady !== 1'b1 || cpuHold !== 1'b1) begin
      errors++; $display("FAIL %s_b0: inReady=%b cpuHold=%b want 1 1", tag, inReady, cpuHold);
    end
    feed(0, gap_len, 1'b0, 200);
    wait_end(50);
    checks++;
    if (got_addr.size() != 3) begin
      errors++; $display("FAIL %s_count: got %0d writes want 3", tag, got_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        base = start_cyc + 3 + 4 * i + gap_len;
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] != base) begin
          errors++;
          $display("FAIL %s_write%0d: got addr=%0h data=%0h cyc=%0d want addr=%0h data=%0h cyc=%0d",
                   tag, i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], base);
        end
      end
      checks++;
      if (end_cyc != got_cyc[2] + 1) begin
        errors++; $display("FAIL %s_done_time: got cyc %0d want %0d", tag, end_cyc, got_cyc[2] + 1);
      end
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpuHold !== 1'b0 || wordCount !== 13'd3) begin
      errors++;
      $display("FAIL %s_final: done=%b err=%b cpuHold=%b wc=%0d want 1 0 0 3", tag, done, err, cpuHold, wordCount);
    end
  endtask

  task automatic test_basic();
    run_fixed(0, "basic");
  endtask

  task automatic test_stall();
    run_fixed(5, "stall");
  endtask

  task automatic test_bad_byte();
    bytes_q.delete();
    bytes_q.push_back(8'h08);
    clear_got();
    pulse_start();
    feed(-1, 0, 1'b0, 20);
    wait_end(20);
    checks++;
    if (got_addr.size() != 0 || err !== 1'b1 || done !== 1'b0 || cpuHold !== 1'b1 || end_cyc != start_cyc + 1) begin
      errors++;
      $display("FAIL bad_byte: writes=%0d err=%b done=%b cpuHold=%b errcyc=%0d want 0 1 0 1 %0d",
               got_addr.size(), err, done, cpuHold, end_cyc, start_cyc + 1);
    end
    bytes_q.delete();
    push_ins(19'd0);
    pulse_start();
    checks++;
    if (err !== 1'b0 || inReady !== 1'b1) begin
      errors++; $display("FAIL bad_restart: err=%b inReady=%b want 0 1", err, inReady);
    end
    feed(-1, 0, 1'b0, 20);
    wait_end(20);
    checks++;
    if (got_addr.size() != 1 || done !== 1'b1 || err !== 1'b0 || wordCount !== 13'd1) begin
      errors++;
      $display("FAIL bad_halt: writes=%0d done=%b err=%b wc=%0d want 1 1 0 1", got_addr.size(), done, err, wordCount);
    end else begin
      checks++;
      if (got_addr[0] !== 12'd0 || got_data[0] !== 19'd0) begin
        errors++; $display("FAIL bad_halt_write: addr=%0h data=%0h want 0 0", got_addr[0], got_data[0]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    int bad;
    for (int p = 0; p < 8; p++) begin
      bytes_q.delete();
      len = $urandom_range(1, 6);
      bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) push_ins(19'($urandom_range(1, 19'h7FFFF)));
      if (bad >= 0) bytes_q[3*bad] = {5'($urandom_range(1, 31)), 3'($urandom_range(0, 7))};
      push_ins(19'd0);
      model();
      clear_got();
      pulse_start();
      feed(-1, 0, 1'b1, 500);
      wait_end(50);
      checks++;
      if (got_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes want %0d", p, got_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          checks++;
          if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL rand%0d_write%0d: got %0h/%0h want %0h/%0h", p, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      checks++;
      if (done !== exp_done || err !== exp_err || cpuHold !== !exp_done || wordCount !== 13'(exp_wc)) begin
        errors++;
        $display("FAIL rand%0d_final: done=%b err=%b cpuHold=%b wc=%0d want %b %b %b %0d",
                 p, done, err, cpuHold, wordCount, exp_done, exp_err, !exp_done, exp_wc);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [18:0] ins1;
    logic [18:0] ins2;
    ins1 = 19'($urandom_range(1, 19'h7FFFF));
    ins2 = 19'($urandom_range(1, 19'h7FFFF));
    clear_got();
    pulse_start();
    inValid = 1'b1; inData = {5'd0, ins1[18:16]};
    @(posedge clk); @(negedge clk);
    inValid = 1'b0;
    pulse_start();
    checks++;
    if (inReady !== 1'b1 || cpuHold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL start_in_b1: inReady=%b cpuHold=%b done=%b want 1 1 0", inReady, cpuHold, done);
    end
    bytes_q.delete();
    bytes_q.push_back(ins1[15:8]); bytes_q.push_back(ins1[7:0]);
    push_ins(ins2);
    feed(-1, 0, 1'b0, 50);
    checks += 2;
    if (wrEn !== 1'b1 || wrAddr !== 12'd1 || wrData !== ins2) begin
      errors++; $display("FAIL second_write: wrEn=%b addr=%0h data=%0h want 1 1 %0h", wrEn, wrAddr, wrData, ins2);
    end
    if (got_addr[0] !== 12'd0 || got_data[0] !== ins1) begin
      errors++; $display("FAIL first_write: addr=%0h data=%0h want 0 %0h", got_addr[0], got_data[0], ins1);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wrEn !== 1'b0 || inReady !== 1'b0 || wrAddr !== 12'd0 || wrData !== 19'd0 || cpuHold !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || wordCount !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid: wrEn=%b inReady=%b addr=%0h data=%0h hold=%b done=%b err=%b wc=%0d want all 0",
               wrEn, inReady, wrAddr, wrData, cpuHold, done, err, wordCount);
    end
    @(negedge clk);
    checks++;
    if (got_addr.size() != 2) begin
      errors++; $display("FAIL rst_mid_writes: got %0d writes want 2", got_addr.size());
    end
  endtask

  task automatic test_full(input bit with_halt);
    int zero_hits = 0;
    bytes_q.delete();
    for (int i = 0; i < 4095; i++) push_ins(19'($urandom_range(1, 19'h7FFFF)));
    push_ins(with_halt ? 19'd0 : 19'h00001);
    push_ins(19'h12345);
    model();
    clear_got();
    pulse_start();
    feed(-1, 0, 1'b0, 4096 * 4 + 100);
    wait_end(100);
    checks++;
    if (got_addr.size() != 4096) begin
      errors++; $display("FAIL full%0d_count: got %0d writes want 4096", with_halt, got_addr.size());
    end else begin
      for (int i = 0; i < 4096; i++) begin
        if (got_addr[i] == 12'd0) zero_hits++;
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL full%0d_write%0d: got %0h/%0h want %0h/%0h", with_halt, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
      checks += 2;
      if (zero_hits != 1) begin
        errors++; $display("FAIL full%0d_wrap: %0d writes to addr 0, want 1", with_halt, zero_hits);
      end
      if (end_cyc != got_cyc[4095] + 1) begin
        errors++; $display("FAIL full%0d_end_time: got cyc %0d want %0d", with_halt, end_cyc, got_cyc[4095] + 1);
      end
    end
    checks++;
    if (done !== exp_done || err !== exp_err || wordCount !== 13'(exp_wc) || exp_wc != 4096) begin
      errors++;
      $display("FAIL full%0d_final: done=%b err=%b wc=%0d want %b %b 4096", with_halt, done, err, wordCount, exp_done, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_byte();
    test_random();
    test_rst_mid();
    reset_dut();
    test_full(1'b0);
    test_full(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
